// File: rtl/fake_netlist_bist_ctrl_if.sv
// BIST control/observe bundle between the fake-netlist core harness and the BIST controller.
// The slave side is the controller; the master side is whoever launches runs and supplies the core response.
interface fake_netlist_bist_ctrl_if #(
  parameter int NUM_IN = 3
);
  logic              start;
  logic [NUM_IN-1:0] vec_out;
  logic              resp_in;
  logic              busy;
  logic              done;
  logic [15:0]       signature;
  logic [15:0]       vec_count;

  modport master (
    output start, resp_in,
    input  vec_out, busy, done, signature, vec_count
  );

  modport slave (
    input  start, resp_in,
    output vec_out, busy, done, signature, vec_count
  );
endinterface

// File: rtl/fake_netlist_bist_ctrl.sv
// LFSR-driven stimulus and MISR response compaction around one combinational fake-netlist core.
// Each vector walks APPLY -> SETTLE (optional) -> CAPTURE; DONE holds the final signature.
module fake_netlist_bist_ctrl #(
  parameter int          NUM_IN  = 3,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          NUM_VEC = 256,
  parameter int          SETTLE  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  fake_netlist_bist_ctrl_if.slave  bus
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] LOAD_VAL  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  SETTLE_L  = 4'(SETTLE);
  localparam logic [15:0] NUM_VEC_L = 16'(NUM_VEC);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_busy;
  logic              w_launch;
  logic [15:0]       w_cnt_inc;
  logic [15:0]       r_lfsr;
  logic [15:0]       r_sig;
  logic [15:0]       r_cnt;
  logic [3:0]        r_settle;
  logic [NUM_IN-1:0] r_vec;
  logic              r_done;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ b};
  endfunction

  assign w_launch  = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_cnt_inc = r_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_next = S_APPLY;
      S_APPLY: begin
        w_busy = 1'b1;
        w_next = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
      end
      S_SETTLE: begin
        w_busy = 1'b1;
        if (r_settle <= 4'd1) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_busy = 1'b1;
        w_next = (w_cnt_inc == NUM_VEC_L) ? S_DONE : S_APPLY;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= LOAD_VAL;
      r_sig    <= 16'h0000;
      r_cnt    <= 16'h0000;
      r_vec    <= '0;
      r_settle <= 4'd0;
      r_done   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_lfsr <= LOAD_VAL;
        r_sig  <= 16'h0000;
        r_cnt  <= 16'h0000;
        r_done <= 1'b0;
      end
      if (r_state == S_APPLY) begin
        r_vec    <= r_lfsr[NUM_IN-1:0];
        r_settle <= SETTLE_L;
      end
      if (r_state == S_SETTLE) r_settle <= r_settle - 4'd1;
      // resp_in is only ever sampled here, after SETTLE+1 cycles of stable stimulus.
      if (r_state == S_CAPTURE) begin
        r_sig  <= misr_step(r_sig, bus.resp_in);
        r_lfsr <= lfsr_step(r_lfsr);
        r_cnt  <= w_cnt_inc;
        if (w_cnt_inc == NUM_VEC_L) r_done <= 1'b1;
      end
    end
  end

  assign bus.vec_out   = r_vec;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.signature = r_sig;
  assign bus.vec_count = r_cnt;

endmodule
